// File: rtl/video_read_arbiter_pkg.sv
// Shared types and widths for the two-master video read arbiter (package video_arb_pkg).
package video_arb_pkg;

    localparam int LEN_W  = 8;
    localparam int BEAT_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef logic port_idx_t;

endpackage

// File: rtl/video_read_arbiter_if.sv
// AXI-style read channel bundle (AR + R); master drives requests, slave answers.
interface video_read_arbiter_if
    import video_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_payload_addr;
    logic [LEN_W-1:0]  ar_payload_len;
    logic [1:0]        ar_payload_burst;

    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_payload_data;
    logic              r_payload_last;

    modport master (
        output ar_valid, ar_payload_addr, ar_payload_len, ar_payload_burst, r_ready,
        input  ar_ready, r_valid, r_payload_data, r_payload_last
    );

    modport slave (
        input  ar_valid, ar_payload_addr, ar_payload_len, ar_payload_burst, r_ready,
        output ar_ready, r_valid, r_payload_data, r_payload_last
    );

endinterface

// File: rtl/video_arb_beat_check.sv
// Counts accepted R beats of the current burst and raises a sticky flag when
// the last marker disagrees with the requested length.
module video_arb_beat_check
    import video_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             handshake,
    input  logic             last,
    input  logic [LEN_W-1:0] len,
    output logic             len_err
);

    logic [BEAT_W-1:0] beat_cnt_reg;
    logic              at_len;

    assign at_len = (beat_cnt_reg == BEAT_W'(len));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_reg <= '0;
        end else if (clear) begin
            beat_cnt_reg <= '0;
        end else if (handshake) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
        end
    end

    // Mismatch either way: last too early/late, or final index reached without last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_err <= 1'b0;
        end else if (handshake && (last != at_len)) begin
            len_err <= 1'b1;
        end
    end

endmodule

// File: rtl/video_read_arbiter.sv
// Two-master AXI read arbiter, one burst outstanding. Define VIDEO_ARB_ROUND_ROBIN_EN
// for round-robin tie-breaking; otherwise master 0 has fixed priority.
module video_read_arbiter
    import video_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    video_read_arbiter_if.slave  m0,
    video_read_arbiter_if.slave  m1,
    video_read_arbiter_if.master s,
    output logic                 len_err
);

    state_t            state_reg, state_next;
    port_idx_t         grant_reg, grant_sel;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [1:0]        burst_reg;
    logic [DATA_W-1:0] r_data;
    logic              any_req, mg_r_ready, r_hs, ar_hs;

    assign any_req    = m0.ar_valid | m1.ar_valid;
    assign mg_r_ready = grant_reg ? m1.r_ready : m0.r_ready;
    assign r_hs       = (state_reg == DATA) && s.r_valid && mg_r_ready;
    assign ar_hs      = (state_reg == ADDR) && s.ar_ready;

`ifdef VIDEO_ARB_ROUND_ROBIN_EN
    // grant_reg keeps the previous winner, so a tie goes to the other port.
    always_comb begin
        if (m0.ar_valid && m1.ar_valid) begin
            grant_sel = ~grant_reg;
        end else begin
            grant_sel = ~m0.ar_valid;
        end
    end
`else
    always_comb begin
        grant_sel = ~m0.ar_valid;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ADDR;
            ADDR:    if (s.ar_ready) state_next = DATA;
            DATA:    if (r_hs && s.r_payload_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_reg <= 1'b1;
            addr_reg  <= '0;
            len_reg   <= '0;
            burst_reg <= '0;
        end else if ((state_reg == IDLE) && any_req) begin
            grant_reg <= grant_sel;
            addr_reg  <= grant_sel ? m1.ar_payload_addr  : m0.ar_payload_addr;
            len_reg   <= grant_sel ? m1.ar_payload_len   : m0.ar_payload_len;
            burst_reg <= grant_sel ? m1.ar_payload_burst : m0.ar_payload_burst;
        end
    end

    // Handshake outputs; ar_ready is gated by reset_n so it drops the instant reset asserts.
    always_comb begin
        m0.ar_ready = 1'b0;
        m1.ar_ready = 1'b0;
        m0.r_valid  = 1'b0;
        m1.r_valid  = 1'b0;
        s.ar_valid  = 1'b0;
        s.r_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (reset_n && any_req) begin
                    m0.ar_ready = ~grant_sel;
                    m1.ar_ready = grant_sel;
                end
            end
            ADDR: s.ar_valid = 1'b1;
            DATA: begin
                m0.r_valid = s.r_valid & ~grant_reg;
                m1.r_valid = s.r_valid & grant_reg;
                s.r_ready  = mg_r_ready;
            end
            default: ;
        endcase
    end

    assign s.ar_payload_addr  = addr_reg;
    assign s.ar_payload_len   = len_reg;
    assign s.ar_payload_burst = burst_reg;

    assign r_data            = s.r_payload_data;
    assign m0.r_payload_data = r_data;
    assign m1.r_payload_data = r_data;
    assign m0.r_payload_last = s.r_payload_last;
    assign m1.r_payload_last = s.r_payload_last;

    video_arb_beat_check u_beat_check (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (ar_hs),
        .handshake (r_hs),
        .last      (s.r_payload_last),
        .len       (len_reg),
        .len_err   (len_err)
    );

endmodule

// File: tb/tb_video_read_arbiter.sv
// Directed + randomized bench for video_read_arbiter with a burst-level reference model.
module tb_video_read_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef VIDEO_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic len_err;

    int checks = 0;
    int errors = 0;

    // Reference model: pending requests, their payloads, last winner, expected len_err.
    bit         pend [2];
    logic [31:0] req_addr [2];
    logic [7:0]  req_len [2];
    logic [1:0]  req_burst [2];
    int          model_last;
    bit          err_model;

    video_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    video_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
    video_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

    video_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
        pend[p]      = 1'b1;
        req_addr[p]  = a;
        req_len[p]   = l;
        req_burst[p] = b;
    endtask

    task automatic drive_masters();
        m0_if.ar_valid         = pend[0];
        m0_if.ar_payload_addr  = req_addr[0];
        m0_if.ar_payload_len   = req_len[0];
        m0_if.ar_payload_burst = req_burst[0];
        m1_if.ar_valid         = pend[1];
        m1_if.ar_payload_addr  = req_addr[1];
        m1_if.ar_payload_len   = req_len[1];
        m1_if.ar_payload_burst = req_burst[1];
    endtask

    function automatic int model_pick();
        if (pend[0] && pend[1]) begin
            return RR ? 1 - model_last : 0;
        end
        return pend[0] ? 0 : 1;
    endfunction

    // Outputs must all be low immediately once reset_n falls, even with requests/beats present.
    task automatic do_reset();
        m0_if.ar_valid = 1'b1;
        m1_if.ar_valid = 1'b1;
        s_if.r_valid   = 1'b1;
        m0_if.r_ready  = 1'b1;
        m1_if.r_ready  = 1'b1;
        reset_n        = 1'b0;
        #1;
        chk("rst_s_ar_valid", 64'(s_if.ar_valid), 64'(0));
        chk("rst_s_r_ready", 64'(s_if.r_ready), 64'(0));
        chk("rst_m_ar_ready", 64'({m0_if.ar_ready, m1_if.ar_ready}), 64'(0));
        chk("rst_m_r_valid", 64'({m0_if.r_valid, m1_if.r_valid}), 64'(0));
        chk("rst_len_err", 64'(len_err), 64'(0));
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        err_model  = 1'b0;
        model_last = 1;
        drive_masters();
        s_if.ar_ready = 1'b0;
        s_if.r_valid  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One IDLE cycle: requests raised, stray beat offered; the model's winner must get ar_ready.
    task automatic arbitrate(output int g);
        @(negedge clk);
        drive_masters();
        s_if.ar_ready       = 1'($urandom_range(0, 1));
        s_if.r_valid        = 1'($urandom_range(0, 1));
        s_if.r_payload_data = $urandom;
        s_if.r_payload_last = 1'b0;
        m0_if.r_ready       = 1'b1;
        m1_if.r_ready       = 1'b1;
        #1;
        g = model_pick();
        chk("idle_m0_ar_ready", 64'(m0_if.ar_ready), 64'(g == 0));
        chk("idle_m1_ar_ready", 64'(m1_if.ar_ready), 64'(g == 1));
        chk("idle_s_ar_valid", 64'(s_if.ar_valid), 64'(0));
        chk("idle_s_r_ready", 64'(s_if.r_ready), 64'(0));
        chk("idle_m_r_valid", 64'({m0_if.r_valid, m1_if.r_valid}), 64'(0));
        chk("idle_len_err", 64'(len_err), 64'(err_model));
        pend[g]    = 1'b0;
        model_last = g;
    endtask

    // Address and data phases of the burst granted to g; memory returns nbeats beats.
    task automatic serve(input int g, input int nbeats, input bit toggle, input int abort_at);
        int  beat = 0;
        int  rx = 0;
        int  err_at;
        int  len_i;
        bit  ar_done = 1'b0;
        bit  hold = 1'b0;
        bit  mg_rdy;
        bit  other_rdy;
        logic [31:0] mg_data;
        logic        mg_last;
        logic        mg_valid;
        logic        other_valid;

        len_i = int'(req_len[g]);
        if (nbeats - 1 == len_i) err_at = -1;
        else err_at = (len_i < nbeats - 1) ? len_i : nbeats - 1;

        for (int cyc = 0; cyc < 20 && !ar_done; cyc++) begin
            @(negedge clk);
            drive_masters();
            s_if.ar_ready       = (cyc >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
            s_if.r_valid        = 1'($urandom_range(0, 1));
            s_if.r_payload_data = $urandom;
            s_if.r_payload_last = 1'b0;
            #1;
            chk("addr_s_ar_valid", 64'(s_if.ar_valid), 64'(1));
            chk("addr_s_ar_addr", 64'(s_if.ar_payload_addr), 64'(req_addr[g]));
            chk("addr_s_ar_len", 64'(s_if.ar_payload_len), 64'(req_len[g]));
            chk("addr_s_ar_burst", 64'(s_if.ar_payload_burst), 64'(req_burst[g]));
            chk("addr_m_ar_ready", 64'({m0_if.ar_ready, m1_if.ar_ready}), 64'(0));
            chk("addr_s_r_ready", 64'(s_if.r_ready), 64'(0));
            chk("addr_m_r_valid", 64'({m0_if.r_valid, m1_if.r_valid}), 64'(0));
            ar_done = s_if.ar_ready;
        end

        for (int cyc = 0; cyc < 2000 && beat < nbeats; cyc++) begin
            @(negedge clk);
            drive_masters();
            s_if.ar_ready = 1'b0;
            if (!hold) begin
                s_if.r_valid        = toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
                s_if.r_payload_data = {8'(beat), 24'($urandom)};
                s_if.r_payload_last = (beat == nbeats - 1);
            end
            mg_rdy    = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            other_rdy = 1'($urandom_range(0, 1));
            m0_if.r_ready = (g == 0) ? mg_rdy : other_rdy;
            m1_if.r_ready = (g == 1) ? mg_rdy : other_rdy;
            if (beat == abort_at) begin
                $display("burst m%0d addr=%08h aborted by reset at beat %0d", g, req_addr[g], beat);
                do_reset();
                return;
            end
            #1;
            mg_valid    = (g == 0) ? m0_if.r_valid : m1_if.r_valid;
            other_valid = (g == 0) ? m1_if.r_valid : m0_if.r_valid;
            mg_data     = (g == 0) ? m0_if.r_payload_data : m1_if.r_payload_data;
            mg_last     = (g == 0) ? m0_if.r_payload_last : m1_if.r_payload_last;
            chk("data_len_err", 64'(len_err), 64'(err_model));
            chk("data_mg_r_valid", 64'(mg_valid), 64'(s_if.r_valid));
            chk("data_other_r_valid", 64'(other_valid), 64'(0));
            chk("data_s_r_ready", 64'(s_if.r_ready), 64'(mg_rdy));
            chk("data_s_ar_valid", 64'(s_if.ar_valid), 64'(0));
            chk("data_m_ar_ready", 64'({m0_if.ar_ready, m1_if.ar_ready}), 64'(0));
            if (s_if.r_valid) begin
                chk("data_mg_r_data", 64'(mg_data), 64'(s_if.r_payload_data));
                chk("data_mg_r_last", 64'(mg_last), 64'(s_if.r_payload_last));
            end
            if (mg_valid && mg_rdy) rx++;
            if (s_if.r_valid && s_if.r_ready) begin
                if (beat == err_at) err_model = 1'b1;
                beat++;
                hold = 1'b0;
            end else begin
                hold = s_if.r_valid;
            end
        end
        chk("beats_forwarded", 64'(beat), 64'(nbeats));
        chk("beats_at_master", 64'(rx), 64'(nbeats));
        $display("burst m%0d addr=%08h len=%0d burst=%0d beats=%0d expect_len_err=%0b",
                 g, req_addr[g], req_len[g], req_burst[g], nbeats, err_model);
    endtask

    initial begin
        int g;
        reset_n = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req_addr[p]  = '0;
            req_len[p]   = '0;
            req_burst[p] = '0;
        end
        model_last = 1;
        err_model  = 1'b0;
        drive_masters();
        m0_if.r_ready       = 1'b0;
        m1_if.r_ready       = 1'b0;
        s_if.ar_ready       = 1'b0;
        s_if.r_valid        = 1'b0;
        s_if.r_payload_data = '0;
        s_if.r_payload_last = 1'b0;

        @(negedge clk);
        do_reset();

        // Single m0 request, 64-beat burst with matching length.
        set_req(0, 32'h0010_0000, 8'd63, 2'd1);
        arbitrate(g);
        serve(g, 64, 1'b0, -1);

        // Both request in the same cycle, no re-request.
        set_req(0, $urandom, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 2)));
        set_req(1, $urandom, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 2)));
        repeat (2) begin
            arbitrate(g);
            serve(g, int'(req_len[g]) + 1, 1'b0, -1);
        end

        // Both request continuously: the winner re-requests right after its burst.
        set_req(0, $urandom, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
        set_req(1, $urandom, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
        repeat (4) begin
            arbitrate(g);
            serve(g, int'(req_len[g]) + 1, 1'b0, -1);
            set_req(g, $urandom, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
        end
        for (int k = 0; k < 4 && (pend[0] || pend[1]); k++) begin
            arbitrate(g);
            serve(g, int'(req_len[g]) + 1, 1'b0, -1);
        end

        // m1 backpressure: r_ready toggles every cycle over an 8-beat burst.
        set_req(1, $urandom, 8'd7, 2'd1);
        arbitrate(g);
        serve(g, 8, 1'b1, -1);

        // last too early: len=3, last on beat 1; next grant proves return to IDLE.
        set_req(0, $urandom, 8'd3, 2'd1);
        arbitrate(g);
        serve(g, 2, 1'b0, -1);
        set_req(1, $urandom, 8'd2, 2'd0);
        arbitrate(g);
        serve(g, 3, 1'b0, -1);
        @(negedge clk);
        do_reset();

        // last too late: len=1, last on beat 3; all four beats still forwarded.
        set_req(0, $urandom, 8'd1, 2'd1);
        arbitrate(g);
        serve(g, 4, 1'b0, -1);
        @(negedge clk);
        do_reset();

        // Random traffic with occasional length mismatches.
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) != 0 || !(pend[0] || pend[1]))
                set_req(0, $urandom, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) != 0)
                set_req(1, $urandom, 8'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
            arbitrate(g);
            serve(g, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : int'(req_len[g]) + 1,
                  1'b0, -1);
        end
        @(negedge clk);
        do_reset();

        // Reset during beat 10 of 64, then a fresh m0 burst.
        set_req(0, 32'h0020_0000, 8'd63, 2'd1);
        arbitrate(g);
        serve(g, 64, 1'b0, 10);
        set_req(0, 32'h0030_0000, 8'd15, 2'd1);
        arbitrate(g);
        serve(g, 16, 1'b0, -1);
        arbitrate_idle_check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Final quiet cycle: no requests, no grant, len_err still as modelled.
    task automatic arbitrate_idle_check();
        @(negedge clk);
        drive_masters();
        s_if.r_valid = 1'b1;
        #1;
        chk("final_m_ar_ready", 64'({m0_if.ar_ready, m1_if.ar_ready}), 64'(0));
        chk("final_s_r_ready", 64'(s_if.r_ready), 64'(0));
        chk("final_len_err", 64'(len_err), 64'(err_model));
    endtask

endmodule

// File: doc/video_read_arbiter.md
VIDEO_READ_ARBITER -- requirements
Module: video_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, AXI read address width.
REQ-002 Parameter DATA_W, default 32, AXI read data width.
REQ-003 clk  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 m0_ar_valid/m0_ar_ready, m0_ar_payload_addr, m0_ar_payload_len, m0_ar_payload_burst  in/out/in/in/in  1/1/ADDR_W/8/2  master 0 (video controller) AR channel.
REQ-006 m0_r_valid/m0_r_ready, m0_r_payload_data, m0_r_payload_last  out/in/out/out  1/1/DATA_W/1  master 0 R channel.
REQ-007 m1_* (same set as REQ-005..006)  as m0  as m0  master 1 (CPU/DMA) channels.
REQ-008 s_ar_valid/s_ar_ready, s_ar_payload_addr/len/burst  out/in/out  1/1/ADDR_W,8,2  downstream AR channel to the memory controller.
REQ-009 s_r_valid/s_r_ready, s_r_payload_data/last  in/out/in  1/1/DATA_W,1  downstream R channel.
REQ-010 len_err  output  1  sticky flag, burst beat count mismatch.

Function
REQ-011 The FSM SHALL have three states: IDLE, ADDR, DATA. One burst SHALL be outstanding at a time.
REQ-012 IDLE: when any mX_ar_valid is high, grant g SHALL be chosen per REQ-020. mg_ar_ready SHALL be driven combinationally high in that cycle. addr/len/burst SHALL be latched at the edge. The FSM SHALL go to ADDR.
REQ-013 In IDLE, every m*_ar_ready for a non-granted port SHALL be 0. If no mX_ar_valid is high, all m*_ar_ready SHALL be 0.
REQ-014 ADDR: s_ar_valid SHALL be 1, carrying the latched payload unchanged. On s_ar_ready the FSM SHALL go to DATA and clear the beat counter.
REQ-015 Latency: mg_ar_valid seen in IDLE SHALL produce s_ar_valid on the next cycle.
REQ-016 DATA: mg_r_valid SHALL equal s_r_valid, mg_r_payload SHALL equal s_r_payload, and s_r_ready SHALL equal mg_r_ready, all combinationally. The other master's r_valid SHALL be 0.
REQ-017 Each R handshake SHALL increment the 9-bit beat counter.
  - On a handshake with last=1, the FSM SHALL return to IDLE.
  - Next grant is possible the cycle after return to IDLE.
REQ-018 len_err SHALL set when either:
  - last arrives with beat index != latched len; or
  - beat index == len is accepted without last.
  In the second case the block SHALL keep forwarding beats until last.
REQ-019 In IDLE and ADDR, s_r_ready SHALL be 0 and both m*_r_valid SHALL be 0. Stray beats SHALL stall downstream and SHALL NOT be dropped.
REQ-020 Arbitration, default: fixed priority, m0 wins when both masters are valid.
REQ-021 The data path SHALL NOT modify payloads. burst SHALL pass through unchanged.

Reset
REQ-022 Assertion of reset_n=0 SHALL, asynchronously:
  - force state to IDLE;
  - force s_ar_valid, s_r_ready, m*_ar_ready, m*_r_valid and len_err to 0;
  - clear the beat counter and the last-grant register to 1.
REQ-023 Reset mid-burst SHALL abandon the burst. No beat SHALL be forwarded until a new grant.
REQ-024 len_err SHALL clear only on reset.

Configuration
REQ-025 Macro VIDEO_ARB_ROUND_ROBIN_EN.
  - Defined: when both masters are valid in IDLE, grant SHALL go to the port not granted last.
  - Defined: when only one master is valid, that port SHALL be granted.
  - Defined: the last-grant register resets to 1, so m0 wins the first tie.
  - Undefined: fixed priority per REQ-020. The last-grant register SHALL be absent.

Structure
REQ-026 Package video_arb_pkg SHALL hold the state enum (IDLE/ADDR/DATA), the LEN_W=8 and BEAT_W=9 constants, and the port-index type.
REQ-027 One sub-module, video_arb_beat_check, SHALL hold the beat counter and len_err logic. It SHALL take handshake, last and len as inputs. Everything else SHALL stay in video_read_arbiter.

Verification
REQ-028 Single request, m0 only: m0 requests addr=0x0010_0000, len=63, burst=1; memory returns 64 beats with last on beat 63.
  - s_ar_valid one cycle after m0_ar_valid.
  - Addr, len and burst unchanged.
  - All 64 beats reach m0.
  - m1_r_valid stays 0.
  - len_err=0.
REQ-029 Simultaneous requests, macro undefined: m0 and m1 request in the same cycle.
  - m0 burst first.
  - m1 granted the cycle after m0 last.
  - m1 address appears on s_ar only after that grant.
REQ-030 Simultaneous requests, macro defined: both masters request continuously.
  - Grant order m0, m1, m0, m1.
REQ-031 Backpressure: m1 r_ready toggles 1/0 every cycle during an 8-beat burst.
  - s_r_ready mirrors m1 r_ready.
  - All 8 beats delivered in order with no duplicates.
REQ-032 Beat mismatch:
  - len=3 with last on beat 1 -> len_err=1 and FSM returns to IDLE.
  - Separately, len=1 with last on beat 3 -> len_err=1 after beat 1, all 4 beats forwarded.
REQ-033 Reset mid-burst: reset_n low during beat 10 of 64.
  - All outputs 0 immediately.
  - After release, state is IDLE.
  - A fresh m0 request completes normally.
